// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions: WB control field layout, wb_sel encodings, register constants.
// Used by the register file top and its write-back select decoder.
// Build option WB_BYPASS_EN (consumed in wb_regfile.sv) does not change anything here.
package wb_regfile_pkg;

   // Bit positions of the 3-bit WB control bundle carried in MEM/WB
   localparam int WB_REGWRITE = 2;
   localparam int WB_SEL_HI   = 1;
   localparam int WB_SEL_LO   = 0;

   // Write-back source select
   typedef enum logic [1:0] {
      SEL_ALU  = 2'b00,
      SEL_MEM  = 2'b01,
      SEL_LINK = 2'b10,
      SEL_RSVD = 2'b11
   } wb_sel_e;

   // Packed view of the WB bundle, MSB first to match the field positions above
   typedef struct packed {
      logic    reg_write;
      wb_sel_e sel;
   } wb_ctrl_t;

   // Destination used by jal-style link write-back
   localparam int LINK_REG_DEF = 31;

   // Hard-wired zero register
   localparam int REG0 = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB/ID side (master) and the write-back register file (slave).
// Carries the MEM/WB payload, both read ports, the commit observation port and the retire count.
// No handshake: every field is sampled or produced every cycle.
interface wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [2:0]        WB;
   logic [ADDR_W-1:0] rd_rt;
   logic [DATA_W-1:0] RD;
   logic [DATA_W-1:0] ALU;
   logic [DATA_W-1:0] pc;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic              wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [31:0]       retire_cnt;

   modport master (
      output WB, rd_rt, RD, ALU, pc, rs_addr, rt_addr,
      input  rs_data, rt_data, wb_we, wb_addr, wb_data, retire_cnt
   );

   modport slave (
      input  WB, rd_rt, RD, ALU, pc, rs_addr, rt_addr,
      output rs_data, rt_data, wb_we, wb_addr, wb_data, retire_cnt
   );
endinterface

// File: rtl/wb_regfile_select.sv
// Write-back select: decodes WB control into commit, destination and data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the write-back stage can never stall.
module wb_select
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int LINK_REG    = LINK_REG_DEF,
   parameter int LINK_OFFSET = 0
) (
   input  logic [2:0]        wb,
   input  logic [ADDR_W-1:0] rd_rt,
   input  logic [DATA_W-1:0] rd,
   input  logic [DATA_W-1:0] alu,
   input  logic [DATA_W-1:0] pc,
   output logic              commit,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);
   localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
   localparam logic [DATA_W-1:0] LINK_ADD = DATA_W'(LINK_OFFSET);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG0);

   wb_ctrl_t          ctrl;
   logic [ADDR_W-1:0] dest;
   logic [DATA_W-1:0] value;
   logic              sel_ok;

   assign ctrl = wb_ctrl_t'(wb);

   // Pick source data and destination; link overrides rd_rt and wraps modulo 2**DATA_W
   always_comb begin
      dest   = rd_rt;
      value  = alu;
      sel_ok = 1'b1;
      case (ctrl.sel)
         SEL_ALU:  value = alu;
         SEL_MEM:  value = rd;
         SEL_LINK: begin
            dest  = LINK_IDX;
            value = pc + LINK_ADD;
         end
         default:  sel_ok = 1'b0;
      endcase
   end

   // A write retires only if enabled, the encoding is legal and it does not target r0
   always_comb begin
      commit = ctrl.reg_write && sel_ok && (dest != ZERO_IDX);
      addr   = commit ? dest  : '0;
      data   = commit ? value : '0;
   end
endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 array, two combinational read ports, commit port, retire counter.
// Latency: write lands on the next rising clk; reads and commit port are combinational.
// Backpressure: none. Option: define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int LINK_REG    = LINK_REG_DEF,
   parameter int LINK_OFFSET = 0
) (
   input  logic        clk,
   input  logic        rst,
   wb_regfile_if.slave bus
);
   localparam int                NREG     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG0);

   logic              commit;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_data;
   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [31:0]       retire_q;

   wb_select #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .LINK_REG    (LINK_REG),
      .LINK_OFFSET (LINK_OFFSET)
   ) u_sel (
      .wb     (bus.WB),
      .rd_rt  (bus.rd_rt),
      .rd     (bus.RD),
      .alu    (bus.ALU),
      .pc     (bus.pc),
      .commit (commit),
      .addr   (c_addr),
      .data   (c_data)
   );

   // Architectural array; commit already excludes r0 so it stays zero after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else if (commit) begin
         rf[c_addr] <= c_data;
      end
   end

   // Read port A: array value, optional write-through, r0 forced to zero last
   always_comb begin
      rs_val = rf[bus.rs_addr];
`ifdef WB_BYPASS_EN
      if (commit && (bus.rs_addr == c_addr)) begin
         rs_val = c_data;
      end
`endif
      if (bus.rs_addr == ZERO_IDX) begin
         rs_val = '0;
      end
   end

   // Read port B: same rules as port A
   always_comb begin
      rt_val = rf[bus.rt_addr];
`ifdef WB_BYPASS_EN
      if (commit && (bus.rt_addr == c_addr)) begin
         rt_val = c_data;
      end
`endif
      if (bus.rt_addr == ZERO_IDX) begin
         rt_val = '0;
      end
   end

   // Retired-write counter, sticks at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_q <= '0;
      end else if (commit && (retire_q != 32'hFFFF_FFFF)) begin
         retire_q <= retire_q + 32'd1;
      end
   end

   assign bus.rs_data    = rs_val;
   assign bus.rt_data    = rt_val;
   assign bus.wb_we      = commit;
   assign bus.wb_addr    = c_addr;
   assign bus.wb_data    = c_data;
   assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, corner sequences, random run.
// Expected values come from hand constants and a spec-level array/counter model.
// Honours WB_BYPASS_EN so the same bench covers both builds.
module tb_wb_regfile;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_regfile dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: plain array of 32 registers and a saturating count
   logic [31:0] mdl [32];
   logic [31:0] mdl_cnt;

   typedef struct {
      logic [2:0]  wb;
      logic [4:0]  rd_rt;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] m_dest(input logic [2:0] wb, input logic [4:0] rd_rt);
      return (wb[1:0] == 2'b10) ? 5'd31 : rd_rt;
   endfunction

   function automatic logic m_commit(input logic [2:0] wb, input logic [4:0] rd_rt);
      return wb[2] && (wb[1:0] != 2'b11) && (m_dest(wb, rd_rt) != 5'd0);
   endfunction

   function automatic logic [31:0] m_value(input logic [2:0] wb, input logic [31:0] rd,
                                           input logic [31:0] alu, input logic [31:0] pc);
      case (wb[1:0])
         2'b00:   return alu;
         2'b01:   return rd;
         default: return pc;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (BYPASS && m_commit(bus.WB, bus.rd_rt) && idx == m_dest(bus.WB, bus.rd_rt))
         return m_value(bus.WB, bus.RD, bus.ALU, bus.pc);
      return mdl[idx];
   endfunction

   task automatic drive(input logic [2:0] wb, input logic [4:0] rd_rt, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt);
      bus.WB = wb; bus.rd_rt = rd_rt; bus.RD = rd; bus.ALU = alu; bus.pc = pc;
      bus.rs_addr = rs; bus.rt_addr = rt;
   endtask

   // Called from negedge with inputs applied: check reads, cross posedge, update model, check count
   task automatic cycle(input string tag);
      #1;
      chk({tag, "_rs"}, bus.rs_data, m_read(bus.rs_addr));
      chk({tag, "_rt"}, bus.rt_data, m_read(bus.rt_addr));
      @(posedge clk);
      if (m_commit(bus.WB, bus.rd_rt)) begin
         mdl[m_dest(bus.WB, bus.rd_rt)] = m_value(bus.WB, bus.RD, bus.ALU, bus.pc);
         if (mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
      end
      #1;
      chk({tag, "_cnt"}, bus.retire_cnt, mdl_cnt);
      @(negedge clk);
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdl_cnt = 32'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tbl[0] = '{3'b100, 5'd5,  32'h0,        32'h0000_1234, 32'h0,         5'd5,  5'd0,  1'b1, 5'd5,  32'h0000_1234};
      tbl[1] = '{3'b101, 5'd0,  32'h0000_DEAD, 32'h0,        32'h0,         5'd0,  5'd5,  1'b0, 5'd0,  32'h0};
      tbl[2] = '{3'b110, 5'd7,  32'h0,        32'h0,         32'h0040_0008, 5'd31, 5'd7,  1'b1, 5'd31, 32'h0040_0008};
      tbl[3] = '{3'b111, 5'd3,  32'h1111_1111, 32'h2222_2222, 32'h3,        5'd3,  5'd31, 1'b0, 5'd0,  32'h0};
      tbl[4] = '{3'b000, 5'd3,  32'h0,        32'h0000_0055, 32'h0,         5'd3,  5'd7,  1'b0, 5'd0,  32'h0};
      tbl[5] = '{3'b011, 5'd3,  32'h0000_0066, 32'h0,        32'h0,         5'd3,  5'd3,  1'b0, 5'd0,  32'h0};
      tbl[6] = '{3'b101, 5'd12, 32'hCAFE_F00D, 32'h0,        32'h0,         5'd12, 5'd5,  1'b1, 5'd12, 32'hCAFE_F00D};
      tbl[7] = '{3'b110, 5'd0,  32'h0,        32'h0,         32'hFFFF_FFFF, 5'd31, 5'd12, 1'b1, 5'd31, 32'hFFFF_FFFF};
      tbl[8] = '{3'b100, 5'd31, 32'h0,        32'h0000_0077, 32'h0,         5'd31, 5'd0,  1'b1, 5'd31, 32'h0000_0077};

      drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      rst_n = 1'b0;
      mdl_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset_cnt", bus.retire_cnt, 32'd0);
      bus.rs_addr = 5'd5; bus.rt_addr = 5'd31;
      #1;
      chk("reset_rs", bus.rs_data, 32'd0);
      chk("reset_rt", bus.rt_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors: commit port against hand constants, reads/count against model
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].wb, tbl[i].rd_rt, tbl[i].rd, tbl[i].alu, tbl[i].pc, tbl[i].rs, tbl[i].rt);
         #1;
         chk($sformatf("vec%0d_we", i),   {31'd0, bus.wb_we}, {31'd0, tbl[i].we});
         chk($sformatf("vec%0d_addr", i), {27'd0, bus.wb_addr}, {27'd0, tbl[i].waddr});
         chk($sformatf("vec%0d_data", i), bus.wb_data, tbl[i].wdata);
         cycle($sformatf("vec%0d", i));
      end
      drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd7);
      #1;
      chk("r5_final", bus.rs_data, 32'h0000_1234);
      chk("r7_untouched", bus.rt_data, 32'h0);
      chk("cnt_after_table", bus.retire_cnt, 32'd5);

      // Same-cycle write and dual read of r9
      drive(3'b100, 5'd9, 32'h0, 32'h0000_1111, 32'h0, 5'd0, 5'd0);
      cycle("r9_pre");
      drive(3'b100, 5'd9, 32'h0, 32'h0000_A5A5, 32'h0, 5'd9, 5'd9);
      #1;
      chk("r9_same_rs", bus.rs_data, BYPASS ? 32'h0000_A5A5 : 32'h0000_1111);
      chk("r9_same_rt", bus.rt_data, BYPASS ? 32'h0000_A5A5 : 32'h0000_1111);
      cycle("r9_wr");
      drive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9);
      #1;
      chk("r9_next_rs", bus.rs_data, 32'h0000_A5A5);
      chk("r9_next_rt", bus.rt_data, 32'h0000_A5A5);

      // Reset asserted mid-cycle while a write to r4 is pending
      drive(3'b100, 5'd4, 32'h0, 32'h0000_0099, 32'h0, 5'd9, 5'd31);
      #2;
      rst_n = 1'b0;
      mdl_reset();
      #1;
      chk("midrst_cnt", bus.retire_cnt, 32'd0);
      chk("midrst_rs", bus.rs_data, 32'd0);
      chk("midrst_rt", bus.rt_data, 32'd0);
      @(posedge clk);
      #1;
      bus.rs_addr = 5'd4;
      #1;
      chk("midrst_r4", bus.rs_data, 32'd0);
      chk("midrst_cnt_edge", bus.retire_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(3'b100, 5'd4, 32'h0, 32'h0000_0042, 32'h0, 5'd4, 5'd9);
      cycle("post_rst_wr");
      chk("post_rst_cnt1", bus.retire_cnt, 32'd1);

      // Saturation: preload counter near the top, then keep committing
      drive(3'b000, 5'd3, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4);
      force dut.retire_q = 32'hFFFF_FFFD;
      #1;
      release dut.retire_q;
      mdl_cnt = 32'hFFFF_FFFD;
      #1;
      chk("sat_preload", bus.retire_cnt, 32'hFFFF_FFFD);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(3'b100, 5'd3, 32'h0, 32'h100 + i, 32'h0, 5'd3, 5'd4);
         cycle($sformatf("sat%0d", i));
      end
      chk("sat_final", bus.retire_cnt, 32'hFFFF_FFFF);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         #1;
         chk("rnd_we", {31'd0, bus.wb_we}, {31'd0, m_commit(bus.WB, bus.rd_rt)});
         chk("rnd_addr", {27'd0, bus.wb_addr},
             m_commit(bus.WB, bus.rd_rt) ? {27'd0, m_dest(bus.WB, bus.rd_rt)} : 32'd0);
         chk("rnd_data", bus.wb_data,
             m_commit(bus.WB, bus.rd_rt) ? m_value(bus.WB, bus.RD, bus.ALU, bus.pc) : 32'd0);
         cycle("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
